// File: rtl/ula_control_unit.sv
// Multi-cycle control FSM for the 16-bit datapath: captures an instruction on Run,
// then sequences register enables, bus select, ALU opcode and memory strobes over 2-4 cycles.
module ula_control_unit #(
  parameter int IR_W = 16,
  parameter int NREG = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [IR_W-1:0] DIN,
  input  logic            GNZ,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [3:0]      BusSel,
  output logic            Ain,
  output logic            Gin,
  output logic [3:0]      AluOp,
  output logic            ADDRin,
  output logic            DOUTin,
  output logic            W_D,
  output logic            Done
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [3:0] OP_LD   = 4'b0000;
  localparam logic [3:0] OP_ST   = 4'b0001;
  localparam logic [3:0] OP_MVNZ = 4'b0010;
  localparam logic [3:0] OP_MV   = 4'b0011;
  localparam logic [3:0] OP_MVI  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SLR  = 4'b1010;

  localparam logic [3:0] BUS_G    = 4'd8;
  localparam logic [3:0] BUS_DIN  = 4'd9;
  localparam logic [3:0] BUS_NONE = 4'd15;

  state_t          state, state_nxt;
  logic [IR_W-1:0] ir;

  logic [3:0]      opcode;
  logic [2:0]      x, y;
  logic [NREG-1:0] rin_x;
  logic            is_alu;
  logic            unused_ir_bits;

  assign opcode = ir[IR_W-1 -: 4];
  assign x      = ir[IR_W-5 -: 3];
  assign y      = ir[IR_W-8 -: 3];
  assign rin_x  = {{(NREG-1){1'b0}}, 1'b1} << x;
  // add, sub, or, slt, sll, slr occupy a contiguous opcode range
  assign is_alu = (opcode >= OP_ADD) && (opcode <= OP_SLR);
  assign unused_ir_bits = ^ir[IR_W-11:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && Run) ir <= DIN;
    end
  end

  always_comb begin
    state_nxt = state;
    IRin      = 1'b0;
    Rin       = '0;
    BusSel    = BUS_NONE;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AluOp     = opcode;
    ADDRin    = 1'b0;
    DOUTin    = 1'b0;
    W_D       = 1'b0;
    Done      = 1'b0;

    case (state)
      T0: begin
        if (Run) begin
          IRin      = 1'b1;
          state_nxt = T1;
        end
      end

      T1: begin
        state_nxt = T0;
        if (opcode == OP_MV) begin
          BusSel = {1'b0, y};
          Rin    = rin_x;
          Done   = 1'b1;
        end else if (opcode == OP_MVI) begin
          BusSel = BUS_DIN;
          Rin    = rin_x;
          Done   = 1'b1;
        end else if (opcode == OP_MVNZ) begin
          // conditional move still completes in one decode cycle
          if (GNZ) begin
            BusSel = {1'b0, y};
            Rin    = rin_x;
          end
          Done = 1'b1;
        end else if (is_alu) begin
          BusSel    = {1'b0, x};
          Ain       = 1'b1;
          state_nxt = T2;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          BusSel    = {1'b0, y};
          ADDRin    = 1'b1;
          state_nxt = T2;
        end else begin
          Done = 1'b1;
        end
      end

      T2: begin
        state_nxt = T0;
        if (is_alu) begin
          BusSel    = {1'b0, y};
          Gin       = 1'b1;
          state_nxt = T3;
        end else if (opcode == OP_LD) begin
          // memory read latency: address was latched in T1
          state_nxt = T3;
        end else if (opcode == OP_ST) begin
          BusSel = {1'b0, x};
          DOUTin = 1'b1;
          W_D    = 1'b1;
          Done   = 1'b1;
        end
      end

      T3: begin
        state_nxt = T0;
        if (is_alu) begin
          BusSel = BUS_G;
          Rin    = rin_x;
          Done   = 1'b1;
        end else if (opcode == OP_LD) begin
          BusSel = BUS_DIN;
          Rin    = rin_x;
          Done   = 1'b1;
        end
      end

      default: state_nxt = T0;
    endcase
  end

endmodule

// File: tb/tb_ula_control_unit.sv
// Directed-vector bench for ula_control_unit; outputs are compared as one packed word per cycle.
module tb_ula_control_unit;

  logic        Clock, Reset, Run, GNZ;
  logic [15:0] DIN;
  logic        IRin, Ain, Gin, ADDRin, DOUTin, W_D, Done;
  logic [7:0]  Rin;
  logic [3:0]  BusSel, AluOp;

  int n_chk  = 0;
  int n_fail = 0;

  ula_control_unit #(.IR_W(16), .NREG(8)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .GNZ(GNZ),
    .IRin(IRin), .Rin(Rin), .BusSel(BusSel), .Ain(Ain), .Gin(Gin),
    .AluOp(AluOp), .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {IRin, Rin, BusSel, Ain, Gin, AluOp, ADDRin, DOUTin, W_D, Done}
  function automatic logic [22:0] pk(input logic irin, input logic [7:0] rin,
                                     input logic [3:0] bus, input logic ain, input logic gin,
                                     input logic [3:0] alu, input logic addr, input logic dout,
                                     input logic wd, input logic done);
    return {irin, rin, bus, ain, gin, alu, addr, dout, wd, done};
  endfunction

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (irin rin bus ain gin alu addr dout wd done), expected %h", tag, obs, exp);
    end
  endtask

  task automatic out_is(input string tag, input logic [22:0] exp);
    #1;
    chk(tag, {IRin, Rin, BusSel, Ain, Gin, AluOp, ADDRin, DOUTin, W_D, Done}, exp);
  endtask

  task automatic step;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; DIN = 16'h0000; GNZ = 1'b0;
    @(negedge Clock);
    step;
    out_is("reset_idle", pk(0, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    Reset = 1'b0;
    out_is("idle_no_run", pk(0, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    step;

    // mvi R1, immediate 0x1234
    Run = 1'b1; DIN = 16'h4200;
    out_is("mvi_t0", pk(1, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    step;
    Run = 1'b0; DIN = 16'h1234;
    out_is("mvi_t1", pk(0, 8'h02, 4'h9, 0, 0, 4'h4, 0, 0, 0, 1));
    step;
    out_is("mvi_back_t0", pk(0, 8'h00, 4'hF, 0, 0, 4'h4, 0, 0, 0, 0));

    // add R2, R1
    Run = 1'b1; DIN = 16'h5440;
    out_is("add_t0", pk(1, 8'h00, 4'hF, 0, 0, 4'h4, 0, 0, 0, 0));
    step;
    Run = 1'b0;
    out_is("add_t1", pk(0, 8'h00, 4'h2, 1, 0, 4'h5, 0, 0, 0, 0));
    step;
    out_is("add_t2", pk(0, 8'h00, 4'h1, 0, 1, 4'h5, 0, 0, 0, 0));
    step;
    out_is("add_t3", pk(0, 8'h04, 4'h8, 0, 0, 4'h5, 0, 0, 0, 1));
    step;
    out_is("add_back_t0", pk(0, 8'h00, 4'hF, 0, 0, 4'h5, 0, 0, 0, 0));

    // mvnz R1, R2 with GNZ low then high
    Run = 1'b1; DIN = 16'h2280; GNZ = 1'b0;
    step;
    Run = 1'b0;
    out_is("mvnz_gnz0_t1", pk(0, 8'h00, 4'hF, 0, 0, 4'h2, 0, 0, 0, 1));
    step;
    Run = 1'b1; GNZ = 1'b1;
    step;
    Run = 1'b0;
    out_is("mvnz_gnz1_t1", pk(0, 8'h02, 4'h2, 0, 0, 4'h2, 0, 0, 0, 1));
    step;
    GNZ = 1'b0;

    // st R3, [R1]
    Run = 1'b1; DIN = 16'h1640;
    out_is("st_t0", pk(1, 8'h00, 4'hF, 0, 0, 4'h2, 0, 0, 0, 0));
    step;
    Run = 1'b0;
    out_is("st_t1", pk(0, 8'h00, 4'h1, 0, 0, 4'h1, 1, 0, 0, 0));
    step;
    out_is("st_t2", pk(0, 8'h00, 4'h3, 0, 0, 4'h1, 0, 1, 1, 1));
    step;
    out_is("st_wd_one_cycle", pk(0, 8'h00, 4'hF, 0, 0, 4'h1, 0, 0, 0, 0));

    // Run held: ld R5,[R1] then illegal 0xF000; DIN changes mid-ld must not reach IR
    Run = 1'b1; DIN = 16'h0A40;
    out_is("ld_t0", pk(1, 8'h00, 4'hF, 0, 0, 4'h1, 0, 0, 0, 0));
    step;
    DIN = 16'hF000;
    out_is("ld_t1_run_ignored", pk(0, 8'h00, 4'h1, 0, 0, 4'h0, 1, 0, 0, 0));
    step;
    out_is("ld_t2_latency", pk(0, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    step;
    out_is("ld_t3", pk(0, 8'h20, 4'h9, 0, 0, 4'h0, 0, 0, 0, 1));
    step;
    out_is("b2b_accept", pk(1, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    step;
    Run = 1'b0;
    out_is("illegal_t1_nop", pk(0, 8'h00, 4'hF, 0, 0, 4'hF, 0, 0, 0, 1));
    step;
    out_is("illegal_back_t0", pk(0, 8'h00, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0));

    // add R3,R3 aborted by reset in T2
    Run = 1'b1; DIN = 16'h56C0;
    step;
    Run = 1'b0;
    out_is("addxx_t1", pk(0, 8'h00, 4'h3, 1, 0, 4'h5, 0, 0, 0, 0));
    step;
    Reset = 1'b1;
    out_is("addxx_t2", pk(0, 8'h00, 4'h3, 0, 1, 4'h5, 0, 0, 0, 0));
    step;
    out_is("abort_reset_1", pk(0, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    step;
    out_is("abort_reset_2", pk(0, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));
    Reset = 1'b0;
    step;
    out_is("abort_no_writeback", pk(0, 8'h00, 4'hF, 0, 0, 4'h0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_control_unit.md
Name: ula_control_unit

Overview:
- Multi-cycle control FSM sequencing the 16-bit processor datapath: register file R0–R7, A/G registers, shared bus mux, address/data-out registers and the ALU.
- Captures each instruction from DIN when Run is asserted.
- Decodes the 4-bit opcode and drives one-hot register enables, bus select, ALU opcode and memory strobes over 2–4 cycles.
- Pulses Done on the last cycle of each instruction.

Parameters:
- IR_W, 16, instruction width; opcode = IR[15:12], X = IR[11:9], Y = IR[8:6], rest ignored.
- NREG, 8, number of general registers; width of Rin.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  IR_W  instruction word in T0; immediate/load data in later cycles.
- GNZ  input  1  datapath flag: G register != 0.
- IRin  output  1  load IR from DIN.
- Rin  output  NREG  one-hot register-file write enable.
- BusSel  output  4  bus source: 0–7 = Rn, 8 = G, 9 = DIN, 15 = none.
- Ain  output  1  load A from bus.
- Gin  output  1  load G from ALU result.
- AluOp  output  4  ALU opcode (= IR[15:12]).
- ADDRin  output  1  load address register from bus.
- DOUTin  output  1  load data-out register from bus.
- W_D  output  1  memory write strobe.
- Done  output  1  one-cycle instruction-complete pulse.

Behaviour:
- Opcodes: ld 0000, st 0001, mvnz 0010, mv 0011, mvi 0100, add 0101, sub 0110, or 0111, slt 1000, sll 1001, slr 1010; 1011–1111 illegal.
- States T0, T1, T2, T3 (2-bit register) plus an internal IR register (IR_W bits).
- Outputs are combinational from state and the internal IR.
- Default in every state: all strobes 0, BusSel = 15, AluOp = IR[15:12].
- Reset: state = T0, IR = 0. In T0 all outputs are 0 except BusSel = 15 and AluOp = 0. Reset asserted in any state aborts the instruction at that edge; no Rin or W_D is issued afterward.
- T0:
  - Run = 0 → stay in T0.
  - Run = 1 → IRin = 1; IR <= DIN on the same edge; next state T1.
- T1 (decode):
  - mv: BusSel = Y, Rin[X] = 1, Done = 1 → T0.
  - mvi: BusSel = 9, Rin[X] = 1, Done = 1 → T0.
  - mvnz: if GNZ, BusSel = Y and Rin[X] = 1; Done = 1 regardless → T0.
  - add/sub/or/slt/sll/slr: BusSel = X, Ain = 1 → T2.
  - ld/st: BusSel = Y, ADDRin = 1 → T2.
  - illegal: Done = 1 only (NOP) → T0.
- T2:
  - ALU ops: BusSel = Y, Gin = 1 → T3.
  - ld: no strobes (memory latency cycle) → T3.
  - st: BusSel = X, DOUTin = 1, W_D = 1, Done = 1 → T0.
- T3:
  - ALU ops: BusSel = 8, Rin[X] = 1, Done = 1 → T0.
  - ld: BusSel = 9, Rin[X] = 1, Done = 1 → T0.
- Latency from Run accepted to Done:
  - mv/mvi/mvnz/illegal: 2 cycles.
  - st: 3 cycles.
  - ALU ops and ld: 4 cycles.
- Run held high: a new instruction is accepted in the T0 cycle immediately after Done. Run outside T0 is ignored.
- Rin is always one-hot or zero; at most one Rin bit per cycle.
- W_D is high only in st/T2.
- X = Y is legal: e.g. add R3,R3 → A = R3, G = R3 + R3.
- AluOp is stable from T1 through T3.

Test Plan:
- Reset high 2 cycles mid add (state T2) → next cycle state T0, Gin = 0, Rin = 0, Done = 0; no write-back occurs.
- Run = 1, DIN = 0x4200 (mvi R1), then DIN = 0x1234 → T1: Rin = 0x02, BusSel = 9, Done = 1; back in T0 after 2 cycles.
- DIN = 0x5440 (add R2,R1) → T1: BusSel = 2, Ain = 1; T2: BusSel = 1, Gin = 1, AluOp = 0101; T3: BusSel = 8, Rin = 0x04, Done = 1.
- DIN = 0x2280 (mvnz R1,R2), first with GNZ = 0 then with GNZ = 1 → GNZ = 0: Rin = 0, Done = 1. GNZ = 1: BusSel = 2, Rin = 0x02, Done = 1.
- DIN = 0x1640 (st R3,[R1]) → T1: BusSel = 1, ADDRin = 1; T2: BusSel = 3, DOUTin = 1, W_D = 1, Done = 1. W_D is high for exactly 1 cycle.
- Run held high with back-to-back ld (0x0A40) then illegal 0xF000 → ld Done at cycle 4, with Rin = 0x20 and BusSel = 9 in T3. Next cycle IRin = 1. Illegal opcode gives Done in T1 with no Rin, Ain or W_D.
